// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the fetch queue: address/word types, queue entry,
// FSM encoding and the JAL offset decoder.
package inst_fetch_queue_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam word_t      ZERO_WORD  = '0;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef struct packed {
    addr_t pc;
    word_t inst;
    logic  pred;
  } ifq_entry_t;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FULL  = 1'b1
  } ifq_state_e;

  function automatic addr_t jal_offset(
    input word_t w
  );
    return {{11{w[31]}}, w[31], w[19:12],
            w[20], w[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetch entries with push/pop/clear.
// Ports: push/pop/clear, wdata in; rdata (head), count, full, empty out.
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  ifq_entry_t wdata,
  output ifq_entry_t rdata,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);

  localparam logic [AW-1:0] NULL_PTR = '0;
  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);

  ifq_entry_t      mem_q [DEPTH];
  ifq_entry_t      mem_d [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  // Full is taken from the registered count, so a
  // pop in the same cycle never frees a slot for a push.
  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    if (clear) begin
      head_d  = NULL_PTR;
      tail_d  = NULL_PTR;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = wdata;
        tail_d        = tail_q + 1'b1;
      end
      if (do_pop) begin
        head_d = head_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= NULL_PTR;
      tail_q  <= NULL_PTR;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: drives cache X port, queues hit words, feeds decode, jump flush.
// Ports: clk,rst_n,rdy | en_rx,pcx,hitx,instx | jump_en,jump_addr |
//   inst_valid,inst_out,inst_pc,inst_pred,dec_ready. Option: IFQ_PREDECODE_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 8,
  parameter int          QUEUE_WIDTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  output logic        en_rx,
  output logic [31:0] pcx,
  input  logic        hitx,
  input  logic [31:0] instx,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_pred,
  input  logic        dec_ready
);

  localparam int CW = QUEUE_WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(QUEUE_DEPTH - 1);

  ifq_state_e      state_q, state_d;
  addr_t           pc_q, pc_d;
  addr_t           next_pc;
  logic            pred;
  logic            push;
  logic            pop;
  logic            flush;
  ifq_entry_t      wdata;
  ifq_entry_t      head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  assign pcx = pc_q;

  always_comb begin
    en_rx = rdy & rst_n
          & (state_q == S_FETCH)
          & ~jump_en;
    push  = en_rx & hitx;
    pop   = inst_valid & dec_ready & rdy;
    flush = rdy & jump_en;
`ifdef IFQ_PREDECODE_EN
    pred = (instx[6:0] == OPCODE_JAL);
    next_pc = pred ? pc_q + jal_offset(instx)
                   : pc_q + 32'd4;
`else
    pred    = 1'b0;
    next_pc = pc_q + 32'd4;
`endif
    wdata.pc   = pc_q;
    wdata.inst = instx;
    wdata.pred = pred;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (1'b1)
      flush:   pc_d = jump_addr;
      push:    pc_d = next_pc;
      default: pc_d = pc_q;
    endcase
    unique case (state_q)
      S_FETCH: begin
        // Only a net gain of one entry can fill the queue.
        if (!flush && push && !pop &&
            fifo_count == CNT_LAST) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (pop || flush) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (QUEUE_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (wdata),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Push is already gated by state; fifo_full is a
  // redundant guard kept visible for clarity of intent.
  always_comb begin
    inst_valid = ~fifo_empty;
    inst_out   = ZERO_WORD;
    inst_pc    = ZERO_WORD;
    inst_pred  = 1'b0;
    if (inst_valid) begin
      inst_out  = head.inst;
      inst_pc   = head.pc;
      inst_pred = head.pred & ~fifo_full | head.pred;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a queue-based reference model.
// Honours IFQ_PREDECODE_EN for the predecode expectations.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        en_rx;
  logic [31:0] pcx;
  logic        hitx;
  logic [31:0] instx;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_pred;
  logic        dec_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          ovr_en = 0;
  logic [31:0] ovr_word = '0;

`ifdef IFQ_PREDECODE_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  inst_fetch_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .en_rx      (en_rx),
    .pcx        (pcx),
    .hitx       (hitx),
    .instx      (instx),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_pred  (inst_pred),
    .dec_ready  (dec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Compare all outputs against the model state.
  task automatic cmp_model();
    logic en_e;
    en_e = rdy & rst_n & (mq.size() < 8) & ~jump_en;
    chk("en_rx", {31'd0, en_rx}, {31'd0, en_e});
    chk("pcx", pcx, m_pc);
    chk("inst_valid", {31'd0, inst_valid},
        {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("inst_out", inst_out, mq[0].inst);
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_pred", {31'd0, inst_pred},
          {31'd0, mq[0].pred});
    end else begin
      chk("inst_out0", inst_out, 32'h0);
      chk("inst_pc0", inst_pc, 32'h0);
      chk("inst_pred0", {31'd0, inst_pred}, 32'h0);
    end
  endtask

  task automatic cyc(input bit h, input bit d,
                     input bit r, input bit j,
                     input logic [31:0] ja);
    int          sz;
    bit          jal;
    logic [31:0] w;
    logic [31:0] off;
    ent_t        e;
    @(negedge clk);
    w = ovr_en ? ovr_word : {m_pc[24:0], 7'h13};
    hitx      = h;
    dec_ready = d;
    rdy       = r;
    jump_en   = j;
    jump_addr = ja;
    instx     = w;
    #1;
    cmp_model();
    if (rst_n && r) begin
      if (j) begin
        mq.delete();
        m_pc = ja;
      end else begin
        sz = mq.size();
        if (sz > 0 && d) void'(mq.pop_front());
        if (h && sz < 8) begin
          jal = PRED_EN && (w[6:0] == 7'h6F);
          off = {{11{w[31]}}, w[31], w[19:12],
                 w[20], w[30:21], 1'b0};
          e.pc = m_pc;
          e.inst = w;
          e.pred = jal;
          mq.push_back(e);
          m_pc = jal ? m_pc + off : m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rdy = 1'b1;
    hitx = 1'b0;
    instx = '0;
    jump_en = 1'b0;
    jump_addr = '0;
    dec_ready = 1'b0;
    m_pc = 32'h0;
    #12;
    cmp_model();
    chk("rst_en", {31'd0, en_rx}, 32'h0);
    chk("rst_pc", pcx, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: streaming hits, decode always ready
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0);
    chk("t1_pcx", pcx, 32'h10);
    chk("t1_ipc", inst_pc, 32'hC);

    // 2: fill the queue with decode stalled
    cyc(1, 1, 1, 1, 32'h0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0);
    chk("t2_pcx", pcx, 32'h20);
    chk("t2_en", {31'd0, en_rx}, 32'h0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("t2_en1", {31'd0, en_rx}, 32'h1);

    // 3: miss held at 0x40 while draining
    for (int i = 0; i < 8; i++) cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
    chk("t3_pcx", pcx, 32'h40);
    chk("t3_en", {31'd0, en_rx}, 32'h1);
    cyc(1, 0, 1, 0, 0);
    chk("t3_ipc", inst_pc, 32'h40);
    chk("t3_val", {31'd0, inst_valid}, 32'h1);

    // 4: jump with five entries queued
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 32'h100);
    chk("t4_val", {31'd0, inst_valid}, 32'h0);
    chk("t4_pcx", pcx, 32'h100);

    // 5: rdy low freezes everything, jump ignored
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h200);
    cyc(1, 1, 0, 0, 0);
    chk("t5_pcx", pcx, 32'h108);
    chk("t5_ipc", inst_pc, 32'h104);

    // 6: JAL predecode at pc 8
    cyc(0, 1, 1, 1, 32'h8);
    ovr_en = 1;
    ovr_word = 32'h0100006F;
    cyc(1, 0, 1, 0, 0);
    ovr_en = 0;
    chk("t6_ipc", inst_pc, 32'h8);
    chk("t6_iout", inst_out, 32'h0100006F);
    chk("t6_pred", {31'd0, inst_pred},
        {31'd0, PRED_EN});
    chk("t6_pcx", pcx, PRED_EN ? 32'h18 : 32'hC);

    // mixed traffic
    for (int i = 0; i < 24; i++)
      cyc((i % 3) != 0, (i % 4) < 2, 1, i == 17, 32'h80);

    // reset during a miss
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
    chk("rm_en", {31'd0, en_rx}, 32'h1);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_pc = 32'h0;
    chk("rm_en0", {31'd0, en_rx}, 32'h0);
    chk("rm_pc0", pcx, 32'h0);
    chk("rm_val0", {31'd0, inst_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rm_pcx", pcx, 32'h8);
    chk("rm_ipc", inst_pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
